trig_link_sequencer: RTL and testbench

- Bring-up controller and source selector in front of the trigger-link frame builder, which serialises 2×56-bit GEM words into 4-cycle 16-bit K-char-delimited frames at clk_160.
- Sequences the frame builder's `ready` input from MGT lock/reset status through a settle window and a comma-alignment window, into run.
- Selects the payload source (live S-bit clusters or test patterns) and holds the payload stable across each 4-cycle frame.
- Counts link drop-outs for slow control.

---
 rtl/trig_link_pkg.sv | 27 ++
 rtl/trig_test_pattern_gen.sv | 44 ++++
 rtl/trig_link_sequencer.sv | 155 +++++++++++++++
 tb/tb_trig_link_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_link_pkg.sv
// Shared constants for the trigger-link bring-up sequencer.
// Link FSM states, test-pattern modes and GEM payload geometry.
package trig_link_pkg;

  localparam int GEM_LINK_W = 56;
  localparam int N_LINKS    = 2;
  localparam int GEM_W      = GEM_LINK_W * N_LINKS;
  localparam int FC_W       = 16;
  localparam int WI_W       = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_RST  = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_ALIGN     = 3'd4,
    ST_RUN       = 3'd5
  } link_state_e;

  typedef enum logic [1:0] {
    TM_LIVE  = 2'd0,
    TM_ZERO  = 2'd1,
    TM_COUNT = 2'd2,
    TM_WALK  = 2'd3
  } test_mode_e;

endpackage

// File: rtl/trig_test_pattern_gen.sv
// Frame counter and walking-one generator, one step per payload latch.
// Ports: run_i (next state is RUN), strobe_i (latch), frame_cnt_o, walk_o.
module trig_test_pattern_gen
  import trig_link_pkg::*;
(
  input  logic             clk_160,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic             strobe_i,
  output logic [FC_W-1:0]  frame_cnt_o,
  output logic [GEM_W-1:0] walk_o
);

  localparam logic [WI_W-1:0] WI_LAST = WI_W'(GEM_W - 1);

  logic [FC_W-1:0] fc_q, fc_d;
  logic [WI_W-1:0] wi_q, wi_d;

  always_comb begin
    fc_d = fc_q;
    wi_d = wi_q;
    if (!run_i) begin
      fc_d = '0;
      wi_d = '0;
    end else if (strobe_i) begin
      fc_d = fc_q + 1'b1;
      wi_d = (wi_q == WI_LAST) ? '0 : wi_q + 1'b1;
    end
  end

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      fc_q <= '0;
      wi_q <= '0;
    end else begin
      fc_q <= fc_d;
      wi_q <= wi_d;
    end
  end

  assign frame_cnt_o = fc_q;
  assign walk_o      = {{(GEM_W-1){1'b0}}, 1'b1} << wi_q;

endmodule

// File: rtl/trig_link_sequencer.sv
// Trigger-link bring-up FSM, payload source select and drop-out count.
// In: clk_160, reset_n, link/MGT status, test_mode, gem_data_i, overflow_i.
// Out: ready, gem_data_o, overflow_o, link_state, drop_cnt.
module trig_link_sequencer
  import trig_link_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int ALIGN_FRAMES  = 64,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                  clk_160,
  input  logic                  reset_n,
  input  logic                  link_enable,
  input  logic                  tx_pll_locked,
  input  logic                  tx_reset_done,
  input  logic [1:0]            test_mode,
  input  logic [GEM_W-1:0]      gem_data_i,
  input  logic                  overflow_i,
  output logic                  ready,
  output logic [GEM_W-1:0]      gem_data_o,
  output logic                  overflow_o,
  output logic [2:0]            link_state,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int ALIGN_CYCLES = ALIGN_FRAMES * 4;
  localparam int WAIT_MAX =
    (SETTLE_CYCLES > ALIGN_CYCLES) ? SETTLE_CYCLES : ALIGN_CYCLES;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] ALIGN_LAST  = WAIT_W'(ALIGN_CYCLES - 1);

  link_state_e           state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  ready_q, ready_d;
  logic [1:0]            phase_q, phase_d;
  logic [GEM_W-1:0]      data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  run_d;
  logic                  latch;
  logic                  drop_evt;
  logic [FC_W-1:0]       frame_cnt;
  logic [GEM_W-1:0]      walk;

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && !link_enable) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE && !tx_pll_locked) begin
      state_d = ST_WAIT_LOCK;
    end else if (state_q inside {ST_SETTLE, ST_ALIGN, ST_RUN}
                 && !tx_reset_done) begin
      state_d = ST_WAIT_RST;
    end else begin
      case (state_q)
        ST_IDLE:      if (link_enable)            state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK:                             state_d = ST_WAIT_RST;
        ST_WAIT_RST:  if (tx_reset_done)          state_d = ST_SETTLE;
        ST_SETTLE:    if (wait_q == SETTLE_LAST)  state_d = ST_ALIGN;
        ST_ALIGN:     if (wait_q == ALIGN_LAST)   state_d = ST_RUN;
        ST_RUN:                                   state_d = ST_RUN;
        default:                                  state_d = ST_IDLE;
      endcase
    end
  end

  // One counter serves both timed windows; it restarts on every state change.
  always_comb begin
    wait_d = '0;
    if (state_d == state_q
        && (state_q == ST_SETTLE || state_q == ST_ALIGN)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Phase tracks the frame builder: 0 on the first RUN cycle, then wraps.
  // The latch fires on RUN entry and at each phase-3 frame boundary.
  always_comb begin
    run_d    = (state_d == ST_RUN);
    ready_d  = run_d;
    phase_d  = (run_d && ready_q) ? phase_q + 2'd1 : 2'd0;
    latch    = run_d && (phase_q == 2'd3 || !ready_q);
    drop_evt = (state_q == ST_RUN) && !run_d && link_enable;
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_evt && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_comb begin
    data_d = data_q;
    ovf_d  = ovf_q;
    if (latch) begin
      unique case (test_mode_e'(test_mode))
        TM_LIVE: begin
          data_d = gem_data_i;
          ovf_d  = overflow_i;
        end
        TM_ZERO: begin
          data_d = '0;
          ovf_d  = 1'b0;
        end
        TM_COUNT: begin
          data_d = {(GEM_W/FC_W){frame_cnt}};
          ovf_d  = 1'b0;
        end
        TM_WALK: begin
          data_d = walk;
          ovf_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      phase_q <= 2'd0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  trig_test_pattern_gen u_pat (
    .clk_160     (clk_160),
    .reset_n     (reset_n),
    .run_i       (run_d),
    .strobe_i    (latch),
    .frame_cnt_o (frame_cnt),
    .walk_o      (walk)
  );

  assign ready      = ready_q;
  assign gem_data_o = data_q;
  assign overflow_o = ovf_q;
  assign link_state = state_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_trig_link_sequencer.sv
// Self-checking bench for trig_link_sequencer.
// Random payloads against a cycles-in-state behavioural model.
module tb_trig_link_sequencer;

  localparam int SC = 16;
  localparam int AF = 2;
  localparam int DW = 8;

  logic         clk_160 = 1'b0;
  logic         reset_n = 1'b0;
  logic         link_enable = 1'b0;
  logic         tx_pll_locked = 1'b0;
  logic         tx_reset_done = 1'b0;
  logic [1:0]   test_mode = 2'd0;
  logic [111:0] gem_data_i = '0;
  logic         overflow_i = 1'b0;
  logic         ready;
  logic [111:0] gem_data_o;
  logic         overflow_o;
  logic [2:0]   link_state;
  logic [7:0]   drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_160 = ~clk_160;

  trig_link_sequencer #(
    .SETTLE_CYCLES (SC),
    .ALIGN_FRAMES  (AF),
    .DROP_CNT_W    (DW)
  ) dut (
    .clk_160       (clk_160),
    .reset_n       (reset_n),
    .link_enable   (link_enable),
    .tx_pll_locked (tx_pll_locked),
    .tx_reset_done (tx_reset_done),
    .test_mode     (test_mode),
    .gem_data_i    (gem_data_i),
    .overflow_i    (overflow_i),
    .ready         (ready),
    .gem_data_o    (gem_data_o),
    .overflow_o    (overflow_o),
    .link_state    (link_state),
    .drop_cnt      (drop_cnt)
  );

  // Reference model: state plus number of cycles spent in it.
  logic [2:0]   m_state;
  int           m_cnt;
  logic         m_ready;
  logic [111:0] m_data;
  logic         m_ovf;
  logic [7:0]   m_drop;
  logic [15:0]  m_fc;
  int           m_wi;
  logic [2:0]   m_nxt;
  logic         m_latch;
  logic [111:0] one112 = 112'd1;

  function automatic logic [2:0] f_next(input logic [2:0] s, input int c,
                                        input logic en, input logic lk,
                                        input logic rd);
    if (s == 3'd0) return en ? 3'd1 : 3'd0;
    if (!en) return 3'd0;
    if (!lk) return 3'd1;
    if (!rd && s >= 3'd3) return 3'd2;
    case (s)
      3'd1: return 3'd2;
      3'd2: return rd ? 3'd3 : 3'd2;
      3'd3: return (c + 1 >= SC) ? 3'd4 : 3'd3;
      3'd4: return (c + 1 >= 4 * AF) ? 3'd5 : 3'd4;
      default: return s;
    endcase
  endfunction

  always_comb begin
    m_nxt   = f_next(m_state, m_cnt, link_enable, tx_pll_locked,
                     tx_reset_done);
    m_latch = (m_nxt == 3'd5) && (m_state != 3'd5 || (m_cnt % 4) == 3);
  end

  always @(posedge clk_160 or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= 3'd0;
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_data  <= '0;
      m_ovf   <= 1'b0;
      m_drop  <= 8'd0;
      m_fc    <= 16'd0;
      m_wi    <= 0;
    end else begin
      m_state <= m_nxt;
      m_cnt   <= (m_nxt == m_state) ? m_cnt + 1 : 0;
      m_ready <= (m_nxt == 3'd5);
      if (m_state == 3'd5 && m_nxt != 3'd5 && link_enable
          && m_drop != 8'hFF)
        m_drop <= m_drop + 8'd1;
      if (m_latch) begin
        case (test_mode)
          2'd0: begin m_data <= gem_data_i; m_ovf <= overflow_i; end
          2'd1: begin m_data <= '0; m_ovf <= 1'b0; end
          2'd2: begin m_data <= {7{m_fc}}; m_ovf <= 1'b0; end
          default: begin m_data <= one112 << m_wi; m_ovf <= 1'b0; end
        endcase
      end
      if (m_nxt != 3'd5) begin
        m_fc <= 16'd0;
        m_wi <= 0;
      end else if (m_latch) begin
        m_fc <= m_fc + 16'd1;
        m_wi <= (m_wi == 111) ? 0 : m_wi + 1;
      end
    end
  end

  logic [124:0] obs, expv;
  assign obs  = {ready, link_state, drop_cnt, overflow_o, gem_data_o};
  assign expv = {m_ready, m_state, m_drop, m_ovf, m_data};

  always @(negedge clk_160) begin
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got %h want %h", $time, obs, expv);
    end
  end

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (!ready && n <= max) begin
      @(negedge clk_160);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_160);
    n_tests++;
    if (obs !== 125'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    reset_n = 1'b1;
    @(negedge clk_160);
    n_tests++;
    if (link_state !== 3'd0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: state %0d ready %b want 0 0",
               link_state, ready);
    end
  endtask

  task automatic test_bringup();
    logic [14:0] seq;
    logic [2:0]  last;
    int          nchg;
    int          n;
    seq = '0;
    nchg = 0;
    n = 0;
    last = link_state;
    link_enable = 1'b1;
    tx_pll_locked = 1'b1;
    tx_reset_done = 1'b1;
    while (!ready && n <= 100) begin
      @(negedge clk_160);
      n++;
      if (link_state !== last) begin
        seq = {seq[11:0], link_state};
        nchg++;
        last = link_state;
      end
    end
    n_tests++;
    if (n !== 27) begin
      n_fail++;
      $display("FAIL bringup_latency: got %0d want 27", n);
    end
    n_tests++;
    if (nchg !== 5 || seq !== 15'o12345) begin
      n_fail++;
      $display("FAIL bringup_seq: got %o (%0d steps) want 12345", seq, nchg);
    end
  endtask

  task automatic test_frame_stability();
    logic [127:0] r;
    logic [111:0] prev;
    logic [111:0] sampled;
    logic         ph3;
    int           bad;
    bad = 0;
    test_mode = 2'd0;
    prev = gem_data_o;
    repeat (48) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      ph3 = (m_state == 3'd5) && ((m_cnt % 4) == 3);
      gem_data_i = r[111:0];
      overflow_i = r[112];
      sampled = r[111:0];
      @(negedge clk_160);
      if ((m_cnt % 4) != 0 && gem_data_o !== prev) bad++;
      prev = gem_data_o;
      if (ph3) begin
        n_tests++;
        if (gem_data_o !== sampled) begin
          n_fail++;
          $display("FAIL frame_latch: got %h want %h", gem_data_o, sampled);
        end
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame_stable: got %0d mid-frame changes want 0", bad);
    end
  endtask

  task automatic test_counter();
    int           n;
    logic [15:0]  fv;
    logic [111:0] want;
    link_enable = 1'b0;
    repeat (2) @(negedge clk_160);
    test_mode = 2'd2;
    overflow_i = 1'b1;
    link_enable = 1'b1;
    wait_ready(100, n);
    n_tests++;
    if (n !== 27) begin
      n_fail++;
      $display("FAIL counter_bringup: got %0d want 27", n);
    end
    for (int f = 0; f < 3; f++) begin
      fv = f[15:0];
      want = {7{fv}};
      n_tests++;
      if (gem_data_o !== want || overflow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL counter_frame%0d: got %h/%b want %h/0",
                 f, gem_data_o, overflow_o, want);
      end
      repeat (4) @(negedge clk_160);
    end
  endtask

  task automatic test_dropout();
    int n;
    tx_pll_locked = 1'b0;
    @(negedge clk_160);
    n_tests++;
    if ({ready, link_state, drop_cnt} !== {1'b0, 3'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL dropout: got r%b s%0d d%0d want r0 s1 d1",
               ready, link_state, drop_cnt);
    end
    tx_pll_locked = 1'b1;
    wait_ready(100, n);
    n_tests++;
    if (n !== 26) begin
      n_fail++;
      $display("FAIL relock_latency: got %0d want 26", n);
    end
  endtask

  task automatic test_priority();
    int n;
    link_enable = 1'b0;
    tx_pll_locked = 1'b0;
    @(negedge clk_160);
    n_tests++;
    if ({ready, link_state, drop_cnt} !== {1'b0, 3'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL enable_priority: got r%b s%0d d%0d want r0 s0 d1",
               ready, link_state, drop_cnt);
    end
    link_enable = 1'b1;
    tx_pll_locked = 1'b1;
    wait_ready(100, n);
    tx_reset_done = 1'b0;
    @(negedge clk_160);
    n_tests++;
    if ({ready, link_state, drop_cnt} !== {1'b0, 3'd2, 8'd2}) begin
      n_fail++;
      $display("FAIL rstdone_loss: got r%b s%0d d%0d want r0 s2 d2",
               ready, link_state, drop_cnt);
    end
    tx_reset_done = 1'b1;
    wait_ready(100, n);
    n_tests++;
    if (n !== 25) begin
      n_fail++;
      $display("FAIL rstdone_latency: got %0d want 25", n);
    end
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 300; i++) begin
      tx_pll_locked = 1'b0;
      @(negedge clk_160);
      tx_pll_locked = 1'b1;
      wait_ready(100, n);
      n_tests++;
      if (n !== 26) begin
        n_fail++;
        $display("FAIL sat_relock%0d: got %0d want 26", i, n);
        break;
      end
    end
    n_tests++;
    if (drop_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
    end
    link_enable = 1'b0;
    tx_pll_locked = 1'b0;
    @(negedge clk_160);
    n_tests++;
    if ({link_state, drop_cnt} !== {3'd0, 8'hFF}) begin
      n_fail++;
      $display("FAIL sat_enable_exit: got s%0d d%0d want s0 d255",
               link_state, drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    test_mode = 2'd3;
    link_enable = 1'b1;
    tx_pll_locked = 1'b1;
    wait_ready(100, n);
    n_tests++;
    if (gem_data_o !== 112'd1) begin
      n_fail++;
      $display("FAIL walk_first: got %h want 1", gem_data_o);
    end
    repeat (6) @(negedge clk_160);
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ready, link_state, drop_cnt} !== 12'd0 || gem_data_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got r%b s%0d d%0d data %h want zeros",
               ready, link_state, drop_cnt, gem_data_o);
    end
    @(negedge clk_160);
    reset_n = 1'b1;
    wait_ready(100, n);
    n_tests++;
    if (n !== 27 || gem_data_o !== 112'd1) begin
      n_fail++;
      $display("FAIL walk_restart: got n%0d %h want n27 1", n, gem_data_o);
    end
    repeat (4) @(negedge clk_160);
    n_tests++;
    if (gem_data_o !== 112'd2) begin
      n_fail++;
      $display("FAIL walk_second: got %h want 2", gem_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_frame_stability();
    test_counter();
    test_dropout();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
